// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle logic ops and an iterative 1-bit-per-cycle shifter
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d, result_q, result_d;
  logic               zero_q, zero_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   alu_y, acc_sh;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  assign shamt     = b[SHAMT_W-1:0];
  assign is_shift  = (ALUctrl == 3'b100) || (ALUctrl[2:1] == 2'b11);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  always_comb begin
    alu_y  = (ALUctrl == 3'b000) ? a + b :
             (ALUctrl == 3'b001) ? a - b :
             (ALUctrl == 3'b010) ? a & b :
             (ALUctrl == 3'b011) ? a | b :
             {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
    // right shifts fill with the sign bit only for SRA
    acc_sh = (op_q == 3'b100) ? {acc_q[WIDTH-2:0], 1'b0}
                              : {(op_q == 3'b111) & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
  end
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (is_shift) begin
          acc_d = a;
          cnt_d = shamt;
          op_d  = ALUctrl;
          if (shamt == '0) begin
            result_d = a;
            zero_d   = (a == '0);
            state_d  = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          result_d = alu_y;
          zero_d   = (alu_y == '0);
          state_d  = DONE;
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = acc_sh;
          zero_d   = (acc_sh == '0);
          state_d  = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit ALUctrl code produced by the control path and returns a registered result with a zero flag.
- Single-cycle codes (ADD/SUB/AND/OR/SLT) complete in one cycle.
- Shift codes run on an iterative 1-bit-per-cycle shifter.
- Valid/ready handshakes on both sides let the pipeline stall for multi-cycle shifts.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; taken from b[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/ctrl presented.
- in_ready  output  1  unit can accept a new operation.
- ALUctrl  input  3  operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; low SHAMT_W bits are the shift amount for shift codes.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered together with result.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Codes:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 101 SLT: signed a<b gives 1, else 0; zero-extended to WIDTH.
  - 100 SLL.
  - 110 SRL.
  - 111 SRA.
- Arithmetic is modulo 2^WIDTH; no carry/overflow outputs.
- States: IDLE, SHIFT, DONE.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, shift counter=0.
- in_ready = (state==IDLE). It is combinational from state only.
- Accept occurs on an edge where in_valid && in_ready.
- IDLE, accept, non-shift code:
  - result <= op(a,b); zero <= (op(a,b)==0).
  - Next state DONE.
  - Latency: out_valid is high the cycle after accept.
- IDLE, accept, shift code:
  - Accumulator <= a; counter <= shamt.
  - Operation code is latched.
  - If shamt==0, go to DONE with result=a, zero=(a==0).
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - Accumulator shifts by 1: SLL fills 0, SRL fills 0, SRA replicates the MSB.
  - Counter decrements.
  - On the edge where the counter goes 1->0, result/zero are loaded from the final shifted value and the state goes to DONE.
- Total shift latency from accept edge to out_valid = shamt+1 cycles (1 when shamt==0).
- DONE:
  - out_valid=1; result/zero held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE and out_valid drops the next cycle.
  - No new operation is accepted in DONE (no bypass), so throughput is at most one op per 2 cycles.
- in_valid while not in IDLE is ignored; operands are not sampled.
- While busy, the unit uses only latched copies of ctrl/operands. a, b and ALUctrl may change freely after accept.
- result/zero hold their last values in IDLE.
- rst asserted in any state, including mid-SHIFT or DONE with out_ready low:
  - Next edge returns to the reset values.
  - The in-flight operation is discarded and no out_valid pulse occurs.
- out_valid never asserts without a preceding accept since the last reset.

Test Plan:
- Reset then ADD: a=0x7FFFFFFF, b=1, ctrl=000 -> one cycle later out_valid=1, result=0x80000000, zero=0. Then SUB a=5,b=5 -> result=0, zero=1.
- SLT signed: a=0xFFFFFFFF, b=1, ctrl=101 -> result=1. Swap operands -> result=0. AND 0xF0F0 & 0x0FF0 -> 0x00F0. OR -> 0xFFF0.
- SRA a=0x80000000, b=31, ctrl=111 -> out_valid exactly 32 cycles after accept, result=0xFFFFFFFF, in_ready=0 throughout. SRL same -> 0x00000001. SLL a=1, b=0x24 (shamt=4) -> 0x10 after 5 cycles.
- Shift with shamt=0 (SLL a=0, b=0x20) -> 1-cycle latency, result=0, zero=1. in_valid held high during SHIFT/DONE must not start a second op until after the output handshake.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result/zero/out_valid stable. out_ready=1 -> IDLE next cycle, in_ready=1.
- rst pulsed on cycle 10 of a 20-cycle SRL -> next cycle IDLE, in_ready=1, out_valid=0, result=0, zero=1. No completion ever appears for the aborted op.
